// File: rtl/fp_add_pipe_if.sv
// Operand/result bundle for the pipelined floating-point adder.
// The master side issues operations, the slave side (the adder) returns results.
interface fp_add_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) ();
    localparam int DATA_W = EXP_W + MAN_W + 1;

    logic              start;
    logic              sub;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              done;
    logic [DATA_W-1:0] res;
    logic              overflow;
    logic              underflow;
    logic              exception;

    modport master (
        output start, sub, op_a, op_b,
        input  done, res, overflow, underflow, exception
    );

    modport slave (
        input  start, sub, op_a, op_b,
        output done, res, overflow, underflow, exception
    );
endinterface

// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor.
// Stage 1 classifies, orders by magnitude and aligns the smaller operand.
// Stage 2 adds or subtracts the significands and counts leading zeros.
// Stage 3 normalises, rounds to nearest-even, and packs result and flags.
// Subnormal inputs are treated as zero; one operation accepted every cycle.
module fp_add_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int DATA_W = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_add_pipe_if.slave bus
);
    // Significand field: hidden, fraction, guard, round, sticky.
    localparam int SIG_W     = MAN_W + 4;
    localparam int LZC_W     = $clog2(SIG_W + 1);
    localparam int XE_W      = EXP_W + 2;
    localparam int SHIFT_MAX = MAN_W + 3;

    localparam logic [EXP_W-1:0]  EXP_ZERO   = {EXP_W{1'b0}};
    localparam logic [EXP_W-1:0]  EXP_ONES   = {EXP_W{1'b1}};
    localparam logic [MAN_W-1:0]  MAN_ZERO   = {MAN_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO  = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] QNAN       = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [SIG_W-1:0]  SIG_ZERO   = {SIG_W{1'b0}};
    localparam logic [SIG_W-1:0]  SIG_STICKY = {{(SIG_W-1){1'b0}}, 1'b1};
    localparam logic [SIG_W:0]    SUM_ZERO   = {(SIG_W+1){1'b0}};
    localparam logic [LZC_W-1:0]  LZC_ZERO   = {LZC_W{1'b0}};
    localparam logic [MAN_W+1:0]  RND_ZERO   = {(MAN_W+2){1'b0}};
    localparam logic signed [XE_W-1:0] XE_ZERO = {XE_W{1'b0}};
    localparam logic signed [XE_W-1:0] XE_ONE  = {{(XE_W-1){1'b0}}, 1'b1};
    localparam logic signed [XE_W-1:0] XE_MAX  = {2'b00, EXP_ONES};

    // Leading-zero count of a significand field; returns SIG_W for an all-zero field.
    function automatic logic [LZC_W-1:0] lzc_f(input logic [SIG_W-1:0] v);
        logic [LZC_W-1:0] n;
        logic             found;
        n     = LZC_W'(SIG_W);
        found = 1'b0;
        for (int i = SIG_W - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n = LZC_W'(SIG_W - 1 - i);
            end else begin
                n = n;
            end
            found = found | v[i];
        end
        return n;
    endfunction

    // ---------------- Stage 1 combinational ----------------
    logic               a_sign_s, b_sign_s;
    logic [EXP_W-1:0]   a_exp_s, b_exp_s;
    logic [MAN_W-1:0]   a_frac_s, b_frac_s;
    logic               a_zero_s, a_inf_s, a_nan_s;
    logic               b_zero_s, b_inf_s, b_nan_s;
    logic               spec_s, spec_exc_s;
    logic [DATA_W-1:0]  spec_res_s;
    logic               swap_s;
    logic               l_sign_s;
    logic [EXP_W-1:0]   l_exp_s, s_exp_s, shift_s;
    logic [MAN_W-1:0]   l_frac_s, s_frac_s;
    logic [2*SIG_W-1:0] s_ext_s;
    logic [SIG_W-1:0]   s_align_s;

    // Unpack and classify both operands, then resolve the special-value result.
    always_comb begin
        a_sign_s   = bus.op_a[DATA_W-1];
        a_exp_s    = bus.op_a[DATA_W-2:MAN_W];
        a_frac_s   = bus.op_a[MAN_W-1:0];
        b_sign_s   = bus.op_b[DATA_W-1] ^ bus.sub;
        b_exp_s    = bus.op_b[DATA_W-2:MAN_W];
        b_frac_s   = bus.op_b[MAN_W-1:0];
        a_zero_s   = (a_exp_s == EXP_ZERO);
        a_inf_s    = (a_exp_s == EXP_ONES) && (a_frac_s == MAN_ZERO);
        a_nan_s    = (a_exp_s == EXP_ONES) && (a_frac_s != MAN_ZERO);
        b_zero_s   = (b_exp_s == EXP_ZERO);
        b_inf_s    = (b_exp_s == EXP_ONES) && (b_frac_s == MAN_ZERO);
        b_nan_s    = (b_exp_s == EXP_ONES) && (b_frac_s != MAN_ZERO);
        spec_s     = 1'b0;
        spec_exc_s = 1'b0;
        spec_res_s = DATA_ZERO;
        if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (a_sign_s != b_sign_s))) begin
            spec_s     = 1'b1;
            spec_exc_s = 1'b1;
            spec_res_s = QNAN;
        end else if (a_inf_s) begin
            spec_s     = 1'b1;
            spec_res_s = {a_sign_s, EXP_ONES, MAN_ZERO};
        end else if (b_inf_s) begin
            spec_s     = 1'b1;
            spec_res_s = {b_sign_s, EXP_ONES, MAN_ZERO};
        end else if (a_zero_s && b_zero_s) begin
            spec_s     = 1'b1;
            spec_res_s = {a_sign_s & b_sign_s, EXP_ZERO, MAN_ZERO};
        end else if (a_zero_s) begin
            spec_s     = 1'b1;
            spec_res_s = {b_sign_s, b_exp_s, b_frac_s};
        end else if (b_zero_s) begin
            spec_s     = 1'b1;
            spec_res_s = {a_sign_s, a_exp_s, a_frac_s};
        end else begin
            spec_s     = 1'b0;
        end
    end

    // Order operands by magnitude (ties keep op_a as the larger) and align the smaller one.
    always_comb begin
        swap_s = (bus.op_b[DATA_W-2:0] > bus.op_a[DATA_W-2:0]);
        if (swap_s) begin
            l_sign_s = b_sign_s;
            l_exp_s  = b_exp_s;
            l_frac_s = b_frac_s;
            s_exp_s  = a_exp_s;
            s_frac_s = a_frac_s;
        end else begin
            l_sign_s = a_sign_s;
            l_exp_s  = a_exp_s;
            l_frac_s = a_frac_s;
            s_exp_s  = b_exp_s;
            s_frac_s = b_frac_s;
        end
        shift_s = l_exp_s - s_exp_s;
        // Lower half of the double-width shift collects everything pushed past the round bit.
        s_ext_s = {1'b1, s_frac_s, 3'b000, {SIG_W{1'b0}}} >> shift_s;
        if (32'(shift_s) >= 32'(SHIFT_MAX)) begin
            s_align_s = SIG_STICKY;
        end else begin
            s_align_s = {s_ext_s[2*SIG_W-1:SIG_W+1], s_ext_s[SIG_W] | (|s_ext_s[SIG_W-1:0])};
        end
    end

    // ---------------- Stage 1 registers ----------------
    logic              s1_valid_r, s1_spec_r, s1_spec_exc_r, s1_sign_r, s1_eff_sub_r;
    logic [DATA_W-1:0] s1_spec_res_r;
    logic [EXP_W-1:0]  s1_exp_r;
    logic [SIG_W-1:0]  s1_sig_l_r, s1_sig_s_r;

    // Capture aligned operands and the special-case decision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r    <= 1'b0;
            s1_spec_r     <= 1'b0;
            s1_spec_exc_r <= 1'b0;
            s1_spec_res_r <= DATA_ZERO;
            s1_sign_r     <= 1'b0;
            s1_eff_sub_r  <= 1'b0;
            s1_exp_r      <= EXP_ZERO;
            s1_sig_l_r    <= SIG_ZERO;
            s1_sig_s_r    <= SIG_ZERO;
        end else begin
            s1_valid_r    <= bus.start;
            s1_spec_r     <= spec_s;
            s1_spec_exc_r <= spec_exc_s;
            s1_spec_res_r <= spec_res_s;
            s1_sign_r     <= l_sign_s;
            s1_eff_sub_r  <= a_sign_s ^ b_sign_s;
            s1_exp_r      <= l_exp_s;
            s1_sig_l_r    <= {1'b1, l_frac_s, 3'b000};
            s1_sig_s_r    <= s_align_s;
        end
    end

    // ---------------- Stage 2 ----------------
    logic [SIG_W:0]   sum_s;
    logic [LZC_W-1:0] lzc_s;

    // Add or subtract significands; the ordering guarantees a non-negative difference.
    always_comb begin
        if (s1_eff_sub_r) begin
            sum_s = {1'b0, s1_sig_l_r} - {1'b0, s1_sig_s_r};
        end else begin
            sum_s = {1'b0, s1_sig_l_r} + {1'b0, s1_sig_s_r};
        end
        lzc_s = lzc_f(sum_s[SIG_W-1:0]);
    end

    logic              s2_valid_r, s2_spec_r, s2_spec_exc_r, s2_sign_r;
    logic [DATA_W-1:0] s2_spec_res_r;
    logic [EXP_W-1:0]  s2_exp_r;
    logic [SIG_W:0]    s2_sum_r;
    logic [LZC_W-1:0]  s2_lzc_r;

    // Capture the raw sum and its leading-zero count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_r    <= 1'b0;
            s2_spec_r     <= 1'b0;
            s2_spec_exc_r <= 1'b0;
            s2_spec_res_r <= DATA_ZERO;
            s2_sign_r     <= 1'b0;
            s2_exp_r      <= EXP_ZERO;
            s2_sum_r      <= SUM_ZERO;
            s2_lzc_r      <= LZC_ZERO;
        end else begin
            s2_valid_r    <= s1_valid_r;
            s2_spec_r     <= s1_spec_r;
            s2_spec_exc_r <= s1_spec_exc_r;
            s2_spec_res_r <= s1_spec_res_r;
            s2_sign_r     <= s1_sign_r;
            s2_exp_r      <= s1_exp_r;
            s2_sum_r      <= sum_s;
            s2_lzc_r      <= lzc_s;
        end
    end

    // ---------------- Stage 3 ----------------
    logic [SIG_W-1:0]        norm_s;
    logic signed [XE_W-1:0]  exp_x_s;
    logic                    round_up_s;
    logic [MAN_W+1:0]        rnd_s;
    logic [MAN_W-1:0]        frac_s;
    logic [DATA_W-1:0]       res_next_s;
    logic                    ovf_next_s, unf_next_s, exc_next_s;

    // Normalise, round to nearest-even, range-check and select the final result.
    always_comb begin
        res_next_s = DATA_ZERO;
        ovf_next_s = 1'b0;
        unf_next_s = 1'b0;
        exc_next_s = 1'b0;
        if (s2_sum_r[SIG_W]) begin
            norm_s  = {s2_sum_r[SIG_W:2], s2_sum_r[1] | s2_sum_r[0]};
            exp_x_s = $signed({2'b00, s2_exp_r}) + XE_ONE;
        end else begin
            norm_s  = s2_sum_r[SIG_W-1:0] << s2_lzc_r;
            exp_x_s = $signed({2'b00, s2_exp_r}) - $signed({{(XE_W-LZC_W){1'b0}}, s2_lzc_r});
        end
        round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        rnd_s      = {1'b0, norm_s[SIG_W-1:3]} + {RND_ZERO[MAN_W+1:1], round_up_s};
        // A carry out of rounding leaves 10.00..0; renormalise by one place.
        if (rnd_s[MAN_W+1]) begin
            exp_x_s = exp_x_s + XE_ONE;
            frac_s  = rnd_s[MAN_W:1];
        end else begin
            frac_s  = rnd_s[MAN_W-1:0];
        end
        if (s2_spec_r) begin
            res_next_s = s2_spec_res_r;
            exc_next_s = s2_spec_exc_r;
        end else if (s2_sum_r == SUM_ZERO) begin
            res_next_s = DATA_ZERO;
        end else if (exp_x_s >= XE_MAX) begin
            res_next_s = {s2_sign_r, EXP_ONES, MAN_ZERO};
            ovf_next_s = 1'b1;
        end else if (exp_x_s <= XE_ZERO) begin
            res_next_s = {s2_sign_r, EXP_ZERO, MAN_ZERO};
            unf_next_s = 1'b1;
        end else begin
            res_next_s = {s2_sign_r, exp_x_s[EXP_W-1:0], frac_s};
        end
    end

    logic              done_r, overflow_r, underflow_r, exception_r;
    logic [DATA_W-1:0] res_r;

    // Register the packed result, flags and completion pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_r      <= 1'b0;
            res_r       <= DATA_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            exception_r <= 1'b0;
        end else begin
            done_r      <= s2_valid_r;
            res_r       <= res_next_s;
            overflow_r  <= ovf_next_s;
            underflow_r <= unf_next_s;
            exception_r <= exc_next_s;
        end
    end

    assign bus.done      = done_r;
    assign bus.res       = res_r;
    assign bus.overflow  = overflow_r;
    assign bus.underflow = underflow_r;
    assign bus.exception = exception_r;
endmodule

// File: tb/tb_fp_add_pipe.sv
// Bench for fp_add_pipe (binary32 configuration): exact-arithmetic reference
// model with a scoreboard, directed vectors, random streaming and mid-flight reset.
module tb_fp_add_pipe;
    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    fp_add_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          issue;
        logic [35:0] exp;
    } sb_t;
    sb_t sb_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact integer sum of both values, then round to 24 significant bits.
    // Returns {res, overflow, underflow, exception}.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic         sa, sb, sign;
        logic [7:0]   ea, eb;
        logic [22:0]  fa, fb;
        logic [299:0] ma, mb, s, q, rem, half;
        int           p, k, e;
        sa = a[31]; ea = a[30:23]; fa = a[22:0];
        sb = b[31] ^ sub; eb = b[30:23]; fb = b[22:0];
        if ((ea == 8'hFF && fa != 23'h0) || (eb == 8'hFF && fb != 23'h0) ||
            (ea == 8'hFF && eb == 8'hFF && sa != sb))
            return {32'h7FC00000, 3'b001};
        if (ea == 8'hFF) return {sa, 8'hFF, 23'h0, 3'b000};
        if (eb == 8'hFF) return {sb, 8'hFF, 23'h0, 3'b000};
        if (ea == 8'h00 && eb == 8'h00) return {sa & sb, 31'h0, 3'b000};
        if (ea == 8'h00) return {sb, b[30:0], 3'b000};
        if (eb == 8'h00) return {sa, a[30:0], 3'b000};
        ma = 300'({1'b1, fa}) << (ea - 8'd1);
        mb = 300'({1'b1, fb}) << (eb - 8'd1);
        if (sa == sb) s = ma + mb;
        else if (ma >= mb) s = ma - mb;
        else s = mb - ma;
        sign = (a[30:0] >= b[30:0]) ? sa : sb;
        if (s == 300'd0) return 35'h0;
        p = 0;
        for (int i = 0; i < 300; i++) if (s[i]) p = i;
        e = p - 22;
        k = p - 23;
        if (k > 0) begin
            q    = s >> k;
            rem  = s & ((300'd1 << k) - 300'd1);
            half = 300'd1 << (k - 1);
            if (rem > half || (rem == half && q[0])) q = q + 300'd1;
        end else begin
            q = s << (-k);
        end
        if (q == (300'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {sign, 8'hFF, 23'h0, 3'b100};
        if (e <= 0) return {sign, 31'h0, 3'b010};
        return {sign, 8'(e), q[22:0], 3'b000};
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        sb_t it;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.sub   = s;
        it.issue  = cyc;
        it.exp    = {1'b1, model(a, b, s)};
        sb_q.push_back(it);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.start = 1'b0;
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
        bus.sub   = 1'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) idle();
        if (sb_q.size() != 0) begin
            total_cnt++;
            $display("FAIL drain: %0d results still outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    function automatic logic [31:0] rand_op(input int base);
        int          k, e;
        logic [22:0] f;
        logic        s;
        k = $urandom_range(0, 19);
        f = 23'($urandom);
        s = 1'($urandom);
        case (k)
            0: e = 0;
            1: begin e = 255; f = 23'h0; end
            2: begin e = 255; f = f | 23'h1; end
            3: e = int'($urandom_range(250, 254));
            4: e = int'($urandom_range(1, 4));
            default: begin
                e = base + int'($urandom_range(0, 60)) - 30;
                if (e < 1) e = 1;
                if (e > 254) e = 254;
            end
        endcase
        return {s, 8'(e), f};
    endfunction

    // Compare process: every done pulse must match the oldest outstanding op, on time.
    initial begin
        sb_t it;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL spurious_done: got done=1 res=%h, required done=0", bus.res);
                end else begin
                    it = sb_q.pop_front();
                    check("latency", 36'(cyc - it.issue), 36'd3);
                    check("result", {bus.done, bus.res, bus.overflow, bus.underflow, bus.exception}, it.exp);
                end
            end else if (sb_q.size() != 0 && cyc >= sb_q[0].issue + 3) begin
                it = sb_q.pop_front();
                total_cnt++;
                $display("FAIL missing_done: got done=%b, required 1 (expected %h)", bus.done, it.exp);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [31:0] a, b;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.op_a  = 32'h0;
        bus.op_b  = 32'h0;

        // Hand-computed values pinning the reference model.
        check("pin_add",      {1'b0, model(32'h3F800000, 32'h40000000, 1'b0)}, {1'b0, 32'h40400000, 3'b000});
        check("pin_cancel",   {1'b0, model(32'h3F800000, 32'h3F800000, 1'b1)}, {1'b0, 32'h00000000, 3'b000});
        check("pin_unf_pos",  {1'b0, model(32'h00800001, 32'h00800000, 1'b1)}, {1'b0, 32'h00000000, 3'b010});
        check("pin_unf_neg",  {1'b0, model(32'h00800000, 32'h00800001, 1'b1)}, {1'b0, 32'h80000000, 3'b010});
        check("pin_tie_even", {1'b0, model(32'h3F800000, 32'h33800000, 1'b0)}, {1'b0, 32'h3F800000, 3'b000});
        check("pin_tie_odd",  {1'b0, model(32'h3F800001, 32'h33800000, 1'b0)}, {1'b0, 32'h3F800002, 3'b000});
        check("pin_above",    {1'b0, model(32'h3F800000, 32'h33800001, 1'b0)}, {1'b0, 32'h3F800001, 3'b000});
        check("pin_ovf",      {1'b0, model(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0)}, {1'b0, 32'h7F800000, 3'b100});
        check("pin_inf_inf",  {1'b0, model(32'h7F800000, 32'hFF800000, 1'b0)}, {1'b0, 32'h7FC00000, 3'b001});
        check("pin_nan",      {1'b0, model(32'h7FC00001, 32'h3F800000, 1'b0)}, {1'b0, 32'h7FC00000, 3'b001});
        check("pin_inf",      {1'b0, model(32'h7F800000, 32'h3F800000, 1'b0)}, {1'b0, 32'h7F800000, 3'b000});
        check("pin_zeros",    {1'b0, model(32'h80000000, 32'h00000000, 1'b1)}, {1'b0, 32'h80000000, 3'b000});

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_state", {bus.done, bus.res, bus.overflow, bus.underflow, bus.exception}, 36'h0);
        rst_n = 1'b1;
        idle();

        // Directed vectors issued back to back (streaming).
        issue(32'h3F800000, 32'h40000000, 1'b0);
        issue(32'h3F800000, 32'h3F800000, 1'b1);
        issue(32'h00800001, 32'h00800000, 1'b1);
        issue(32'h00800000, 32'h00800001, 1'b1);
        issue(32'h3F800000, 32'h33800000, 1'b0);
        issue(32'h3F800001, 32'h33800000, 1'b0);
        issue(32'h3F800000, 32'h33800001, 1'b0);
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
        issue(32'h7F800000, 32'hFF800000, 1'b0);
        issue(32'h7FC00001, 32'h3F800000, 1'b0);
        issue(32'h7F800000, 32'h3F800000, 1'b0);
        // One-cycle gap between starts.
        issue(32'h40A00000, 32'h3F800000, 1'b1);
        idle();
        issue(32'hC0400000, 32'h40400000, 1'b0);
        drain();

        // Random traffic with random start gaps.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                base = int'($urandom_range(1, 254));
                a = rand_op(base);
                b = rand_op(base);
                if ($urandom_range(0, 9) == 0) b = a;
                issue(a, b, 1'($urandom));
            end
        end
        drain();

        // Reset while two operations are in flight: neither may complete.
        issue(32'h3F800000, 32'h40000000, 1'b0);
        issue(32'h40400000, 32'h3F800000, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        rst_n = 1'b0;
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_flush", {bus.done, bus.res, bus.overflow, bus.underflow, bus.exception}, 36'h0);
        repeat (4) idle();
        issue(32'h40000000, 32'h40000000, 1'b0);
        drain();
        repeat (3) idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
- Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor. It is the next generation of the FPU add unit.
- Adds generic exponent/mantissa widths, an add/sub mode, round-to-nearest-even, special-value handling (zero/inf/NaN) and real overflow/underflow/exception flags.
- Sits in the FPU datapath behind the operand mux and accepts one operation per cycle. Fixed 3-cycle latency, start/done handshake.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
- MAN_W, 23, stored fraction width (hidden bit excluded)
- DATA_W, EXP_W+MAN_W+1, operand/result width (derived; do not override)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- start  in  1  operands valid this cycle
- sub  in  1  0: op_a+op_b, 1: op_a-op_b (sign of op_b inverted at unpack)
- op_a  in  DATA_W  operand A {sign, exp, frac}
- op_b  in  DATA_W  operand B
- done  out  1  res/flags valid; pulses exactly 3 cycles after matching start
- res  out  DATA_W  rounded result
- overflow  out  1  finite inputs rounded to ±inf
- underflow  out  1  nonzero result flushed to ±0
- exception  out  1  invalid operation (NaN input, or inf-inf)

Behaviour:
- Reset: on clk edge with rst_n=0, all pipeline registers and done, res, overflow, underflow, exception clear to 0. Ops in flight are discarded; no done for them.
- Pipeline: no stall, no backpressure. start accepted every cycle. done(t+3)=start(t). res/flags register every cycle; contents are meaningful only when done=1.
- Input classes per operand:
  - exp==0 → zero. Subnormals are flushed to zero (FTZ); this is not flagged.
  - exp==all-ones, frac==0 → inf.
  - exp==all-ones, frac!=0 → NaN.
- Stage 1 (unpack/align):
  - Effective b sign = op_b sign XOR sub.
  - Order operands by full magnitude {exp,frac}. The larger is L, the smaller is S. On equal magnitude, L=op_a.
  - Shift S's significand {1,frac} right by d=expL-expS into a MAN_W+4 bit field (hidden, frac, G, R, sticky). Sticky = OR of all bits shifted past R.
  - If d ≥ MAN_W+3, S becomes sticky-only.
  - Register the special-case decision alongside the datapath.
- Stage 2 (add):
  - Same effective signs → add, with a 1-bit carry-out.
  - Different effective signs → subtract S from L. The result is never negative because of the magnitude ordering.
  - Compute the leading-zero count of the sum; register the sum and the count.
- Stage 3 (normalise/round/pack):
  - Carry → shift right 1, sticky |= dropped bit, exp+1.
  - Otherwise shift left by lzc, exp-lzc.
  - Round to nearest, ties to even, on G/R/S. Mantissa overflow from rounding → exp+1, frac=0.
  - Sign = sign of L.
  - Exact zero from cancellation → +0.
  - Zero+zero → sign = AND of the effective signs.
- Result exponent ≥ all-ones → res = ±inf, overflow=1.
- Result exponent ≤ 0 with nonzero sum → res = ±0 (sign kept), underflow=1.
- Special precedence (highest first):
  1. Any NaN, or inf + (-inf) by effective signs → canonical qNaN {0, all-ones, 1 followed by zeros}, exception=1.
  2. Any inf → that inf, no flags.
  3. One zero operand → the other operand (sign per effective sign).
- Flags are mutually exclusive per result.
- Widths: exponent arithmetic is carried in EXP_W+2 signed bits so under/overflow detection cannot wrap.

Test Plan:
- Basic add/latency (EXP_W=8, MAN_W=23): start=1 with 0x3F800000 + 0x40000000, sub=0 → done exactly 3 cycles later, res=0x40400000, all flags 0.
- Cancellation/underflow:
  - 0x3F800000 - 0x3F800000 (sub=1) → 0x00000000, flags 0.
  - 0x00800001 - 0x00800000 → 0x00000000, underflow=1.
  - 0x00800000 - 0x00800001 → 0x80000000, underflow=1.
- Rounding:
  - 0x3F800000 + 0x33800000 (exact tie) → 0x3F800000.
  - 0x3F800001 + 0x33800000 → 0x3F800002.
  - 0x3F800000 + 0x33800001 → 0x3F800001.
- Overflow/specials:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1.
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, exception=1.
  - 0x7FC00001 + 0x3F800000 → 0x7FC00000, exception=1.
  - 0x7F800000 + 0x3F800000 → 0x7F800000, flags 0.
- Streaming: 4 consecutive start cycles with distinct operand pairs → 4 consecutive done pulses with in-order correct results; a start gap of 1 cycle yields a 1-cycle done gap.
- Reset mid-flight: issue 2 starts, drive rst_n=0 for one cycle one edge later → done, res and flags are 0 on the following cycle, no done for the discarded ops; a new start after release completes normally in 3 cycles.
